// File: rtl/path_delay_meter.sv
// Measures the propagation delay of an external path in clock cycles via launch/capture.
// Define PATH_DELAY_ACCUM_EN to add a saturating accumulator of successful measurements.
module path_delay_meter #(
  parameter int CNT_W       = 16,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 4095,
  parameter int INVERTING   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             launch,
  input  logic             pathResult,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] delayCount
`ifdef PATH_DELAY_ACCUM_EN
  ,
  input  logic             clrAccum,
  output logic [31:0]      accumTotal,
  output logic [15:0]      runCount
`endif
);

  localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic INV = (INVERTING != 0);

  typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, MEASURE, DONE} stateT;

  stateT               state;
  logic                s1;
  logic                s2;
  logic                expLevel;
  logic [SETTLE_W-1:0] settleCnt;
  logic [CNT_W-1:0]    cnt;

  assign expLevel = launch ^ INV;
  assign busy     = (state != IDLE);

  // pathResult is asynchronous to clk; only s2 is ever used for decisions
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pathResult;
      s2 <= s1;
    end
  end

  // The count includes the two synchronizer stages, so a wire-only path reads as 2
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      launch     <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      delayCount <= '0;
      settleCnt  <= '0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          launch <= 1'b0;
          if (start) begin
            settleCnt <= '0;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          launch <= 1'b0;
          if (settleCnt == SETTLE_LAST) begin
            if (s2 == expLevel) begin
              state <= LAUNCH;
            end else begin
              delayCount <= '0;
              timeout    <= 1'b1;
              done       <= 1'b1;
              state      <= DONE;
            end
          end else begin
            settleCnt <= settleCnt + SETTLE_W'(1);
          end
        end
        LAUNCH: begin
          launch <= 1'b1;
          cnt    <= '0;
          state  <= MEASURE;
        end
        MEASURE: begin
          if (s2 == expLevel) begin
            delayCount <= cnt;
            timeout    <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else if (cnt == TIMEOUT_VAL) begin
            delayCount <= TIMEOUT_VAL;
            timeout    <= 1'b1;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          launch <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PATH_DELAY_ACCUM_EN
  logic [32:0] accumSum;

  assign accumSum = {1'b0, accumTotal} + 33'(delayCount);

  // clrAccum wins over a done landing in the same cycle
  always_ff @(posedge clk) begin
    if (rst || clrAccum) begin
      accumTotal <= '0;
      runCount   <= '0;
    end else if (done && !timeout) begin
      accumTotal <= accumSum[32] ? '1 : accumSum[31:0];
      if (runCount != '1) runCount <= runCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_path_delay_meter.sv
// Scoreboard bench for path_delay_meter: stimulus pushes expected results, a monitor checks each done.
// Accumulator checks are compiled in when PATH_DELAY_ACCUM_EN is defined.
module tb_path_delay_meter;

  localparam int CNT_W       = 16;
  localparam int SETTLE_CYC  = 16;
  localparam int TIMEOUT_CYC = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             launch;
  logic             pathResult;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] delayCount;
`ifdef PATH_DELAY_ACCUM_EN
  logic             clrAccum;
  logic [31:0]      accumTotal;
  logic [15:0]      runCount;
`endif

  typedef enum int {PATH_DELAY, PATH_STUCK0, PATH_STUCK1} pathModeT;
  typedef struct packed {
    logic             timeout;
    logic [CNT_W-1:0] count;
  } expT;

  pathModeT    pathMode;
  int          pathDelay;
  logic [31:0] delayLine;
  expT         expQ[$];
  expT         monExp;
  logic        prevDone = 1'b0;
  int          compared = 0;
  int          mismatched = 0;

  path_delay_meter #(
    .CNT_W(CNT_W),
    .SETTLE_CYC(SETTLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .INVERTING(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .launch(launch),
    .pathResult(pathResult),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .delayCount(delayCount)
`ifdef PATH_DELAY_ACCUM_EN
    ,
    .clrAccum(clrAccum),
    .accumTotal(accumTotal),
    .runCount(runCount)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural path: a chain of N stages modelled as an N-cycle delay of launch
  always @(posedge clk) begin
    if (rst) delayLine <= '0;
    else     delayLine <= {delayLine[30:0], launch};
  end

  always_comb begin
    case (pathMode)
      PATH_STUCK0: pathResult = 1'b0;
      PATH_STUCK1: pathResult = 1'b1;
      default:     pathResult = (pathDelay == 0) ? launch : delayLine[pathDelay-1];
    endcase
  end

  function automatic expT refModel(input pathModeT mode, input int d);
    expT r;
    case (mode)
      PATH_STUCK1: begin r.timeout = 1'b1; r.count = '0; end
      PATH_STUCK0: begin r.timeout = 1'b1; r.count = CNT_W'(TIMEOUT_CYC); end
      default: begin
        if (d + 2 <= TIMEOUT_CYC) begin
          r.timeout = 1'b0;
          r.count   = CNT_W'(d + 2);
        end else begin
          r.timeout = 1'b1;
          r.count   = CNT_W'(TIMEOUT_CYC);
        end
      end
    endcase
    return r;
  endfunction

  // Monitor: every done must match the oldest queued expectation and last exactly one cycle
  always @(negedge clk) begin
    if (prevDone) begin
      compared++;
      if (launch !== 1'b0 || done !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL afterDone: launch=%b done=%b, expected launch=0 done=0", launch, done);
      end
    end
    if (done === 1'b1) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpectedDone: done=1 with no run outstanding, delayCount=%0d", delayCount);
      end else begin
        monExp = expQ.pop_front();
        if (timeout !== monExp.timeout || delayCount !== monExp.count) begin
          mismatched++;
          $display("[TB] FAIL result: timeout=%b delayCount=%0d, expected timeout=%b delayCount=%0d",
                   timeout, delayCount, monExp.timeout, monExp.count);
        end
      end
    end
    prevDone <= (done === 1'b1);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input pathModeT mode, input int d, input bit expectDone);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy === 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (busy !== 1'b0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL idleWait: busy=%b after %0d cycles, expected 0", busy, guard);
    end
    pathMode  = mode;
    pathDelay = d;
    if (expectDone) expQ.push_back(refModel(mode, d));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int bound, output int cycles);
    cycles = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      cycles = i + 1;
      if (done === 1'b1) return;
    end
    compared++;
    mismatched++;
    $display("[TB] FAIL doneWait: done=0 after %0d cycles, expected 1", bound);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int guard;
`ifdef PATH_DELAY_ACCUM_EN
    int refSum;
    int refRuns;
    clrAccum = 1'b0;
`endif
    rst       = 1'b1;
    start     = 1'b0;
    pathMode  = PATH_DELAY;
    pathDelay = 0;
    repeat (3) @(negedge clk);
    checkOutput("resetLaunch", launch, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetTimeout", timeout, 0);
    checkOutput("resetDelayCount", delayCount, 0);
    rst = 1'b0;

    applyStimulus(PATH_DELAY, 0, 1'b1);
    waitDone(300, n);
    applyStimulus(PATH_DELAY, 7, 1'b1);
    waitDone(300, n);
    applyStimulus(PATH_STUCK0, 0, 1'b1);
    waitDone(400, n);
    applyStimulus(PATH_STUCK1, 0, 1'b1);
    waitDone(300, n);
    checkOutput("stuckHighLatency", n, SETTLE_CYC);

    // A start pulse mid-run must neither restart nor queue a run
    applyStimulus(PATH_DELAY, 5, 1'b1);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(300, n);
    repeat (30) @(negedge clk);
    checkOutput("startNotQueued", busy, 0);

    // start held high chains two runs back to back
    pathMode  = PATH_DELAY;
    pathDelay = 3;
    expQ.push_back(refModel(PATH_DELAY, 3));
    expQ.push_back(refModel(PATH_DELAY, 3));
    start = 1'b1;
    waitDone(300, n);
    waitDone(300, n);
    start = 1'b0;

    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 9) == 0) applyStimulus(PATH_STUCK1, 0, 1'b1);
      else                           applyStimulus(PATH_DELAY, int'($urandom_range(0, 12)), 1'b1);
      waitDone(400, n);
    end

    // Reset while MEASURE holds count 5 aborts the run silently
    applyStimulus(PATH_DELAY, 12, 1'b0);
    guard = 0;
    while (launch !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("launchRose", launch, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortLaunch", launch, 0);
    checkOutput("abortDelayCount", delayCount, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortTimeout", timeout, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("abortStaysIdle", busy, 0);

`ifdef PATH_DELAY_ACCUM_EN
    clrAccum = 1'b1;
    @(negedge clk);
    clrAccum = 1'b0;
    refSum  = 0;
    refRuns = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(PATH_DELAY, 7, 1'b1);
      refSum  += int'(refModel(PATH_DELAY, 7).count);
      refRuns += 1;
      waitDone(300, n);
    end
    applyStimulus(PATH_STUCK0, 0, 1'b1);
    waitDone(400, n);
    repeat (2) @(negedge clk);
    checkOutput("accumTotal", accumTotal, refSum);
    checkOutput("runCount", runCount, refRuns);
    clrAccum = 1'b1;
    @(negedge clk);
    clrAccum = 1'b0;
    @(negedge clk);
    checkOutput("accumCleared", accumTotal, 0);
    checkOutput("runCountCleared", runCount, 0);
`endif

    repeat (5) @(negedge clk);
    checkOutput("queueEmpty", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
